// File: rtl/line_sum_window_gen.sv
// rtl/line_sum_window_gen.sv - 8-row stack of 8-pixel horizontal line sums for the window-sum stage
//
// Purpose: accepts a raster stream of signed pixels, keeps an 8-pixel running
// horizontal sum per row (restarting at column 0), and stacks the current
// row's sum with the sums of the 7 previous rows at the same column.
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   frame_start       with pix_valid, marks the pixel as (row 0, col 0)
//   pix_valid         pix_data carries a pixel this cycle
//   pix_data          signed pixel, PIX_W bits
//   win_valid         single-cycle pulse: win_data is a full in-frame window
//   win_data          lane i (SUM_W bits) = line sum of row (r-i) at column c
//   win_row, win_col  position (r, c) of the window's bottom-right pixel
module line_sum_window_gen #(
  parameter int PIX_W = 16,
  parameter int SUM_W = 32,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               win_valid,
  output logic [8*SUM_W-1:0] win_data,
  output logic [15:0]        win_row,
  output logic [15:0]        win_col
);
  localparam int CW = $clog2(IMG_W);
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  logic [15:0]        col_q, col_d, row_q, row_d;
  logic [15:0]        cur_col, cur_row;
  logic [SUM_W-1:0]   pix_ext;
  logic [SUM_W-1:0]   hsum_q, hsum_d;
  logic [SUM_W-1:0]   sr_q [8];
  logic [SUM_W-1:0]   sr_d [8];
  logic [SUM_W-1:0]   lb_mem [7][IMG_W];
  logic [SUM_W-1:0]   lb_rd [7];

  logic               s1_valid_q, s1_valid_d;
  logic [8*SUM_W-1:0] s1_data_q, s1_data_d;
  logic [15:0]        s1_row_q, s1_row_d, s1_col_q, s1_col_d;

  logic               win_valid_q, win_valid_d;
  logic [8*SUM_W-1:0] win_data_q, win_data_d;
  logic [15:0]        win_row_q, win_row_d, win_col_q, win_col_d;

  always_comb begin
    // frame_start overrides the counters for this pixel only; counting resumes from (0,0)
    cur_col = frame_start ? 16'd0 : col_q;
    cur_row = frame_start ? 16'd0 : row_q;
    pix_ext = {{(SUM_W-PIX_W){pix_data[PIX_W-1]}}, pix_data};
    for (int k = 0; k < 7; k++) lb_rd[k] = lb_mem[k][cur_col[CW-1:0]];

    col_d      = col_q;
    row_d      = row_q;
    hsum_d     = hsum_q;
    for (int k = 0; k < 8; k++) sr_d[k] = sr_q[k];
    s1_valid_d = pix_valid;
    s1_data_d  = s1_data_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;

    if (pix_valid) begin
      if (cur_col == LAST_COL) begin
        col_d = 16'd0;
        row_d = (cur_row == LAST_ROW) ? 16'd0 : cur_row + 16'd1;
      end else begin
        col_d = cur_col + 16'd1;
        row_d = cur_row;
      end

      // sr holds the previous 8 pixels of this row; sr[7] is the one leaving the window
      sr_d[0] = pix_ext;
      if (cur_col == 16'd0) begin
        hsum_d = pix_ext;
        for (int k = 1; k < 8; k++) sr_d[k] = '0;
      end else begin
        hsum_d = hsum_q + pix_ext - sr_q[7];
        for (int k = 1; k < 8; k++) sr_d[k] = sr_q[k-1];
      end

      s1_data_d[SUM_W-1:0] = hsum_d;
      for (int k = 0; k < 7; k++) s1_data_d[(k+1)*SUM_W +: SUM_W] = lb_rd[k];
      s1_row_d = cur_row;
      s1_col_d = cur_col;
    end

    win_valid_d = s1_valid_q && (s1_row_q >= 16'd7) && (s1_col_q >= 16'd7);
    win_data_d  = win_valid_d ? s1_data_q : win_data_q;
    win_row_d   = win_valid_d ? s1_row_q  : win_row_q;
    win_col_d   = win_valid_d ? s1_col_q  : win_col_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hsum_q      <= '0;
      for (int k = 0; k < 8; k++) sr_q[k] <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hsum_q      <= hsum_d;
      for (int k = 0; k < 8; k++) sr_q[k] <= sr_d[k];
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Line buffers: read-before-write at the same column shifts each row one buffer deeper.
  // Contents are never reset; a new frame rewrites every column before row 7 can qualify.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_mem[0][cur_col[CW-1:0]] <= hsum_d;
      for (int k = 1; k < 7; k++) lb_mem[k][cur_col[CW-1:0]] <= lb_rd[k-1];
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
endmodule
